// File: rtl/ecpeta_rr_sched.sv
// Round-robin scheduler sharing one ECPETA approximate adder between REQ requesters.
// Operands are registered, the sum and an exact-vs-approximate flag are captured, then returned tagged by id.

module ecpeta #(
   parameter int n = 16,
   parameter int k = 11
) (
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   output logic [n-1:0] sum
);

   logic sat;

   // Low part: scan from the top approximate bit down; the first position where
   // both inputs are 1 forces that bit and everything below it to 1. The upper
   // part is exact, with its carry-in predicted from the top approximate bit pair.
   always_comb begin
      sum = '0;
      sat = 1'b0;
      for (int i = k - 1; i >= 0; i--) begin
         if (sat) begin
            sum[i] = 1'b1;
         end else if (A[i] && B[i]) begin
            sum[i] = 1'b1;
            sat    = 1'b1;
         end else begin
            sum[i] = A[i] ^ B[i];
         end
      end
      sum[n-1:k] = A[n-1:k] + B[n-1:k] + (n-k)'(A[k-1] & B[k-1]);
   end

endmodule

module ecpeta_rr_sched #(
   parameter int N = 16,
   parameter int K = 11,
   parameter int REQ = 4,
   localparam int IDW = $clog2(REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REQ-1:0]   req_valid,
   output logic [REQ-1:0]   req_ready,
   input  logic [REQ*N-1:0] req_a,
   input  logic [REQ*N-1:0] req_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [N-1:0]     resp_sum,
   output logic [IDW-1:0]   resp_id,
   output logic             resp_err,
   output logic [15:0]      ops_count
);

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t         state_q;
   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] id_q;
   logic [N-1:0]   a_q;
   logic [N-1:0]   b_q;
   logic [N-1:0]   sum_q;
   logic           err_q;
   logic [15:0]    ops_q;

   logic           grant_vld;
   logic [IDW-1:0] grant_id;
   logic [IDW-1:0] idx;
   logic [N-1:0]   sel_a;
   logic [N-1:0]   sel_b;
   logic [N-1:0]   approx_sum;
   logic [N-1:0]   exact_sum;

   // Search ptr, ptr+1, ... (mod REQ); walking backwards lets the nearest hit win.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      idx       = '0;
      for (int i = REQ - 1; i >= 0; i--) begin
         idx = ptr_q + IDW'(i);
         if (req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_id  = idx;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < REQ; i++) begin
         if (grant_id == IDW'(i)) begin
            sel_a = req_a[i*N +: N];
            sel_b = req_b[i*N +: N];
         end
      end
   end

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; a producer holds valid and data until then, ready never waits on
   // anything but valid and registered state.
   assign req_ready = (state_q == IDLE && grant_vld) ? (REQ'(1) << grant_id) : '0;

   ecpeta #(.n(N), .k(K)) u_ecpeta (
      .A   (a_q),
      .B   (b_q),
      .sum (approx_sum)
   );

   assign exact_sum = a_q + b_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         err_q   <= 1'b0;
         ops_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  a_q     <= sel_a;
                  b_q     <= sel_b;
                  id_q    <= grant_id;
                  state_q <= CALC;
               end
            end
            CALC: begin
               sum_q   <= approx_sum;
               err_q   <= (approx_sum != exact_sum);
               state_q <= RESP;
            end
            RESP: begin
               // Priority moves only once the consumer has taken the result.
               if (resp_ready) begin
                  ptr_q   <= id_q + IDW'(1);
                  ops_q   <= ops_q + 16'd1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign resp_valid = (state_q == RESP);
   assign resp_sum   = sum_q;
   assign resp_id    = id_q;
   assign resp_err   = err_q;
   assign ops_count  = ops_q;

endmodule
